data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have a parameter WAIT_STATES, default 1, giving the number of wait cycles inserted before ready (legal range 0..7).
REQ-002 The block SHALL have a parameter ADDR_W, default 10, giving the RAM word-address width (RAM depth 2**ADDR_W x 16).
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port MemR, input, 1 bit: read request from the CPU.
REQ-006 Port MemW, input, 1 bit: write request from the CPU.
REQ-007 Port addr, input, 16 bits: word address, from the ALU result.
REQ-008 Port wdata, input, 16 bits: write data, from register operand 2.
REQ-009 Port inr, input, 4 bits: external switch inputs.
REQ-010 Port readBus, output, 16 bits: read data returned to the CPU.
REQ-011 Port ready, output, 1 bit: one-cycle access-complete strobe.
REQ-012 Port outvalue, output, 16 bits: memory-mapped output register.

Function
REQ-013 The FSM SHALL have three states: IDLE, WAIT, RESP.
REQ-014 In IDLE, if MemR or MemW is high, the FSM SHALL latch addr, wdata and the operation, then go to WAIT (WAIT_STATES>0) or RESP (WAIT_STATES=0).
REQ-015 WAIT SHALL count WAIT_STATES cycles, then go to RESP.
REQ-016 RESP SHALL assert ready for exactly one cycle, then return to IDLE; a request held high in that IDLE cycle starts a new access.
REQ-017 Latency: a request first sampled at edge N SHALL produce ready high during cycle N+1+WAIT_STATES.
REQ-018 A write SHALL commit at the edge that ends the RESP cycle, using the latched address and data.
REQ-019 Read data SHALL be valid on readBus during the RESP cycle and SHALL hold until the next read completes.
REQ-020 If MemR and MemW are both high when the request is latched, the access SHALL be treated as a write, and readBus SHALL be left unchanged.
REQ-021 If the request deasserts during WAIT, the access SHALL abort: return to IDLE, no ready, no write.
REQ-022 The address map SHALL be:
- addr[15:12]==0: RAM at addr[ADDR_W-1:0].
- 0xF000: outvalue, read/write.
- 0xF001: {12'b0, inr}, read-only.
- 0xF002: free-running cycle counter, read-only.
REQ-023 Accesses to unmapped addresses, and writes to read-only registers, SHALL complete normally with ready; the write is ignored and the read returns 0x0000.
REQ-024 The cycle counter SHALL increment every clock and wrap from 0xFFFF to 0x0000.
REQ-025 RAM read SHALL be synchronous, with the address issued no later than the last cycle before RESP.

Reset
REQ-026 Reset SHALL force:
- state IDLE, ready 0, readBus 0x0000, outvalue 0x0000, counter 0x0000.
- latched request cleared.
REQ-027 Reset SHALL NOT clear RAM contents.
REQ-028 Reset asserted mid-access SHALL abort the access with no write committed and no ready.

Configuration
REQ-029 Macro DMEM_MMIO_EN, when defined, SHALL compile in the 0xF000-0xF002 registers and the counter.
REQ-030 When DMEM_MMIO_EN is undefined, the block SHALL behave as follows:
- Those addresses behave as unmapped.
- outvalue is tied to 0x0000.
- The counter logic is absent.

Structure
REQ-031 A shared package/header dmem_pkg SHALL hold the FSM state encodings, the MMIO address constants (0xF000, 0xF001, 0xF002) and the RAM region-select value.
REQ-032 The RAM SHALL be a sub-module dmem_ram: single-port, synchronous read and write, parameterised by ADDR_W.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- W=1: MemW, addr 0x0005, wdata 0xBEEF; then MemR, addr 0x0005. -> Each ready appears 2 cycles after the request; readBus is 0xBEEF.
- W=0: back-to-back reads of 0x0000 and 0x0001 held high. -> ready pulses every 2nd cycle; readBus updates on each ready.
- MemR and MemW both high: addr 0x0010, wdata 0x1234. -> RAM[0x10] becomes 0x1234; readBus is unchanged.
- MMIO: write 0x00A5 to 0xF000, then read 0xF000; read 0xF001 with inr=4'hC. -> outvalue is 0x00A5; reads return 0x00A5 and 0x000C.
- Abort: W=3, MemW dropped in the 2nd WAIT cycle. -> No ready; RAM is unchanged. Repeat with reset in WAIT. -> Same result; outvalue is 0.
- Counter: read 0xF002 twice, 10 cycles apart. -> Difference is 10 (mod 2^16); counter wrap at 0xFFFF is checked.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   - FSM state encoding (IDLE / WAIT / RESP)
//   - memory-mapped register addresses (output reg, switch inputs, cycle counter)
//   - RAM region select value (addr[15:12]) and the region decode helper
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [15:0] MMIO_OUT_ADDR = 16'hF000;
    localparam logic [15:0] MMIO_IN_ADDR  = 16'hF001;
    localparam logic [15:0] MMIO_CNT_ADDR = 16'hF002;

    localparam logic [3:0]  RAM_REGION    = 4'h0;

    // True when the word address falls in the RAM window.
    function automatic logic is_ram_addr(input logic [15:0] a);
        return (a[15:12] == RAM_REGION);
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-port 16-bit RAM, synchronous read and write.
//   clk   : clock
//   we    : write enable (wins over re on the shared port)
//   re    : read enable; rdata only changes on an enabled read
//   addr  : word address, ADDR_W bits
//   wdata : write data
//   rdata : registered read data, held between reads
// Contents are deliberately not reset.
module dmem_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       wdata,
    output logic [15:0]       rdata
);

    logic [15:0] mem_r [0:(2**ADDR_W)-1];
    logic [15:0] rdata_r;

    // Single shared port: a write takes the cycle, otherwise an enabled read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end else if (re) begin
            rdata_r <= mem_r[addr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: CPU data-memory slave with programmable wait states.
// A request (MemR/MemW) seen in IDLE is latched, optionally waits WAIT_STATES
// cycles (aborting if the request drops), then gives a one-cycle ready in RESP.
// Writes commit at the edge that ends RESP; read data appears in RESP and holds
// until the next completed read. MemR+MemW together is a write.
//
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   MemR, MemW     : read / write request
//   addr, wdata    : word address and write data
//   inr            : 4 external switch inputs (readable at 0xF001)
//   readBus        : read data
//   ready          : one-cycle completion strobe
//   outvalue       : memory-mapped output register (0xF000)
//
// Build option: define DMEM_MMIO_EN to include the 0xF000..0xF002 registers and
// the free-running cycle counter. Without it those addresses read as 0x0000,
// ignore writes, and outvalue is tied to 0x0000.
module data_mem_responder #(
    parameter int WAIT_STATES = 1,
    parameter int ADDR_W      = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemR,
    input  logic        MemW,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic [3:0]  inr,
    output logic [15:0] readBus,
    output logic        ready,
    output logic [15:0] outvalue
);

    import dmem_pkg::*;

    localparam logic [2:0] WAIT_LAST = 3'(WAIT_STATES - 1);

    state_e      state_r;
    state_e      state_n_s;
    logic [2:0]  wait_cnt_r;
    logic [15:0] addr_r;
    logic [15:0] wdata_r;
    logic        wr_r;
    logic        ready_r;
    logic        rd_sel_ram_r;
    logic [15:0] rd_mmio_r;
    logic [15:0] outvalue_r;

    logic        req_s;
    logic        cur_wr_s;
    logic [15:0] cur_addr_s;
    logic        enter_resp_s;
    logic        ram_re_s;
    logic        ram_we_s;
    logic [15:0] ram_rdata_s;
    logic [15:0] mmio_val_s;
    logic        unused_s;

    assign req_s = MemR | MemW;

    // Next-state logic: IDLE accepts, WAIT counts or aborts, RESP lasts one cycle.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    state_n_s = (WAIT_STATES == 0) ? RESP : WAIT;
                end else begin
                    state_n_s = IDLE;
                end
            end
            WAIT: begin
                if (!req_s) begin
                    state_n_s = IDLE;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    state_n_s = RESP;
                end else begin
                    state_n_s = WAIT;
                end
            end
            RESP: begin
                state_n_s = IDLE;
            end
            default: begin
                state_n_s = IDLE;
            end
        endcase
    end

    // With zero wait states the RAM read must be issued in the accepting IDLE
    // cycle, so the live inputs stand in for the not-yet-latched request.
    always_comb begin
        cur_wr_s   = wr_r;
        cur_addr_s = addr_r;
        if (state_r == IDLE) begin
            cur_wr_s   = MemW;
            cur_addr_s = addr;
        end else begin
            cur_wr_s   = wr_r;
            cur_addr_s = addr_r;
        end
    end

    assign enter_resp_s = (state_n_s == RESP) && !reset;
    assign ram_re_s     = enter_resp_s && !cur_wr_s && is_ram_addr(cur_addr_s);
    assign ram_we_s     = (state_r == RESP) && wr_r && is_ram_addr(addr_r) && !reset;

    dmem_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .re    (ram_re_s),
        .addr  (cur_addr_s[ADDR_W-1:0]),
        .wdata (wdata_r),
        .rdata (ram_rdata_s)
    );

`ifdef DMEM_MMIO_EN
    logic [15:0] cnt_r;

    // Output register write (at the end of RESP) and free-running cycle counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            outvalue_r <= 16'h0000;
            cnt_r      <= 16'h0000;
        end else begin
            cnt_r <= cnt_r + 16'd1;
            if ((state_r == RESP) && wr_r && (addr_r == MMIO_OUT_ADDR)) begin
                outvalue_r <= wdata_r;
            end
        end
    end

    // Register-file read mux; anything not decoded here reads as zero.
    always_comb begin
        mmio_val_s = 16'h0000;
        case (cur_addr_s)
            MMIO_OUT_ADDR: mmio_val_s = outvalue_r;
            MMIO_IN_ADDR:  mmio_val_s = {12'h000, inr};
            MMIO_CNT_ADDR: mmio_val_s = cnt_r;
            default:       mmio_val_s = 16'h0000;
        endcase
    end
`else
    assign outvalue_r = 16'h0000;

    // No registers compiled in: every non-RAM address reads as zero.
    always_comb begin
        mmio_val_s = 16'h0000;
    end
`endif

    // Bits that are only decoded in some build/parameter combinations.
    assign unused_s = ^{inr, addr_r, cur_addr_s};

    // Main state register, request latch, ready strobe and read-data capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            wait_cnt_r   <= 3'd0;
            addr_r       <= 16'h0000;
            wdata_r      <= 16'h0000;
            wr_r         <= 1'b0;
            ready_r      <= 1'b0;
            rd_sel_ram_r <= 1'b0;
            rd_mmio_r    <= 16'h0000;
        end else begin
            state_r <= state_n_s;
            ready_r <= (state_n_s == RESP);
            if ((state_r == IDLE) && req_s) begin
                addr_r  <= addr;
                wdata_r <= wdata;
                wr_r    <= MemW;
            end
            if (state_r == WAIT) begin
                wait_cnt_r <= wait_cnt_r + 3'd1;
            end else begin
                wait_cnt_r <= 3'd0;
            end
            // Only completing reads move readBus; writes leave it untouched.
            if (enter_resp_s && !cur_wr_s) begin
                rd_sel_ram_r <= is_ram_addr(cur_addr_s);
                rd_mmio_r    <= mmio_val_s;
            end
        end
    end

    // Both readBus sources are registers; the select is registered too.
    assign readBus  = rd_sel_ram_r ? ram_rdata_s : rd_mmio_r;
    assign ready    = ready_r;
    assign outvalue = outvalue_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (WAIT_STATES 1, 0, 3) checked
// against a behavioural memory/register model held in plain arrays.
module tb_data_mem_responder;

    localparam int WS [3] = '{1, 0, 3};

    logic        clk;
    logic        rst_a    [3];
    logic        mem_r_a  [3];
    logic        mem_w_a  [3];
    logic [15:0] addr_a   [3];
    logic [15:0] wdata_a  [3];
    logic [3:0]  inr_a    [3];
    logic [15:0] rbus_a   [3];
    logic        rdy_a    [3];
    logic [15:0] outv_a   [3];

    // reference model state
    logic [15:0] ram_m  [3][1024];
    logic [15:0] out_m  [3];
    logic [15:0] last_rd[3];
    logic [15:0] cyc    [3];

    int n_chk;
    int n_pass;

    data_mem_responder #(.WAIT_STATES(1), .ADDR_W(10)) u_dut_w1 (
        .clk(clk), .reset(rst_a[0]), .MemR(mem_r_a[0]), .MemW(mem_w_a[0]),
        .addr(addr_a[0]), .wdata(wdata_a[0]), .inr(inr_a[0]),
        .readBus(rbus_a[0]), .ready(rdy_a[0]), .outvalue(outv_a[0]));

    data_mem_responder #(.WAIT_STATES(0), .ADDR_W(10)) u_dut_w0 (
        .clk(clk), .reset(rst_a[1]), .MemR(mem_r_a[1]), .MemW(mem_w_a[1]),
        .addr(addr_a[1]), .wdata(wdata_a[1]), .inr(inr_a[1]),
        .readBus(rbus_a[1]), .ready(rdy_a[1]), .outvalue(outv_a[1]));

    data_mem_responder #(.WAIT_STATES(3), .ADDR_W(10)) u_dut_w3 (
        .clk(clk), .reset(rst_a[2]), .MemR(mem_r_a[2]), .MemW(mem_w_a[2]),
        .addr(addr_a[2]), .wdata(wdata_a[2]), .inr(inr_a[2]),
        .readBus(rbus_a[2]), .ready(rdy_a[2]), .outvalue(outv_a[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Elapsed clocks since reset for each instance.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst_a[i]) cyc[i] <= 16'h0000;
            else          cyc[i] <= cyc[i] + 16'd1;
        end
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected read value from the address map; the counter value is the one
    // before the edge that entered the response cycle.
    function automatic logic [15:0] model_read(input int d, input logic [15:0] a, input logic [3:0] iv);
        if (a[15:12] == 4'h0) return ram_m[d][a[9:0]];
`ifdef DMEM_MMIO_EN
        if (a == 16'hF000) return out_m[d];
        if (a == 16'hF001) return {12'h000, iv};
        if (a == 16'hF002) return cyc[d] - 16'd1;
`endif
        return 16'h0000;
    endfunction

    // One complete access, called at a negedge with the instance idle.
    task automatic access(input int d, input logic rd, input logic wr, input logic [15:0] a,
                          input logic [15:0] wd, input logic [3:0] iv, output logic [15:0] rv);
        int lat;
        lat = 0;
        mem_r_a[d] = rd;
        mem_w_a[d] = wr;
        addr_a[d]  = a;
        wdata_a[d] = wd;
        inr_a[d]   = iv;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (rdy_a[d]) begin
                lat = k;
                break;
            end
        end
        chk($sformatf("latency d%0d a=%h", d, a), 16'(lat), 16'(WS[d] + 1));
        rv = rbus_a[d];
        if (lat != 0) begin
            if (!wr) last_rd[d] = model_read(d, a, iv);
            chk($sformatf("readBus d%0d a=%h r%0d w%0d", d, a, rd, wr), rbus_a[d], last_rd[d]);
        end
        mem_r_a[d] = 1'b0;
        mem_w_a[d] = 1'b0;
        @(posedge clk);
        if ((lat != 0) && wr) begin
            if (a[15:12] == 4'h0) ram_m[d][a[9:0]] = wd;
`ifdef DMEM_MMIO_EN
            if (a == 16'hF000) out_m[d] = wd;
`endif
        end
        @(negedge clk);
        chk($sformatf("ready_one_cycle d%0d", d), {15'h0, rdy_a[d]}, 16'h0000);
        chk($sformatf("outvalue d%0d", d), outv_a[d], out_m[d]);
    endtask

    logic [15:0] rv, rv1, rv2, mm_a5, mm_c;
    int          seen;

    initial begin
        n_chk  = 0;
        n_pass = 0;
        for (int i = 0; i < 3; i++) begin
            rst_a[i] = 1'b1; mem_r_a[i] = 1'b0; mem_w_a[i] = 1'b0;
            addr_a[i] = 16'h0; wdata_a[i] = 16'h0; inr_a[i] = 4'h0;
            out_m[i] = 16'h0; last_rd[i] = 16'h0;
        end
`ifdef DMEM_MMIO_EN
        mm_a5 = 16'h00A5; mm_c = 16'h000C;
`else
        mm_a5 = 16'h0000; mm_c = 16'h0000;
`endif
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("reset ready",   {15'h0, rdy_a[i]}, 16'h0000);
            chk("reset readBus", rbus_a[i], 16'h0000);
            chk("reset outval",  outv_a[i], 16'h0000);
            rst_a[i] = 1'b0;
        end
        @(negedge clk);

        // write then read back, one wait state
        access(0, 1'b0, 1'b1, 16'h0005, 16'hBEEF, 4'h0, rv);
        access(0, 1'b1, 1'b0, 16'h0005, 16'h0000, 4'h0, rv);
        chk("w1 readback", rv, 16'hBEEF);

        // zero wait states, back-to-back held reads
        access(1, 1'b0, 1'b1, 16'h0000, 16'h1111, 4'h0, rv);
        access(1, 1'b0, 1'b1, 16'h0001, 16'h2222, 4'h0, rv);
        mem_r_a[1] = 1'b1; addr_a[1] = 16'h0000;
        @(negedge clk);
        chk("b2b rdy0", {15'h0, rdy_a[1]}, 16'h0001);
        chk("b2b data0", rbus_a[1], 16'h1111);
        addr_a[1] = 16'h0001;
        @(negedge clk);
        chk("b2b gap", {15'h0, rdy_a[1]}, 16'h0000);
        chk("b2b hold", rbus_a[1], 16'h1111);
        @(negedge clk);
        chk("b2b rdy1", {15'h0, rdy_a[1]}, 16'h0001);
        chk("b2b data1", rbus_a[1], 16'h2222);
        mem_r_a[1] = 1'b0; last_rd[1] = 16'h2222;
        @(negedge clk);
        chk("b2b end", {15'h0, rdy_a[1]}, 16'h0000);
        @(negedge clk);

        // read and write together behave as a write
        access(0, 1'b1, 1'b1, 16'h0010, 16'h1234, 4'h0, rv);
        chk("both keeps readBus", rv, 16'hBEEF);
        access(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 4'h0, rv);
        chk("both wrote", rv, 16'h1234);

        // memory-mapped registers and unmapped space
        access(0, 1'b0, 1'b1, 16'hF000, 16'h00A5, 4'h0, rv);
        chk("mmio outvalue", outv_a[0], mm_a5);
        access(0, 1'b1, 1'b0, 16'hF000, 16'h0000, 4'h0, rv);
        chk("mmio rd F000", rv, mm_a5);
        access(0, 1'b1, 1'b0, 16'hF001, 16'h0000, 4'hC, rv);
        chk("mmio rd F001", rv, mm_c);
        access(0, 1'b0, 1'b1, 16'hF001, 16'hFFFF, 4'hC, rv);
        access(0, 1'b1, 1'b0, 16'hF001, 16'h0000, 4'hC, rv);
        chk("mmio F001 ro", rv, mm_c);
        access(0, 1'b0, 1'b1, 16'h8000, 16'h7777, 4'h0, rv);
        access(0, 1'b1, 1'b0, 16'h8000, 16'h0000, 4'h0, rv);
        chk("unmapped rd", rv, 16'h0000);

        // abort by dropping the request in the 2nd wait cycle
        access(2, 1'b0, 1'b1, 16'h0020, 16'h5A5A, 4'h0, rv);
        mem_w_a[2] = 1'b1; addr_a[2] = 16'h0020; wdata_a[2] = 16'hDEAD;
        @(negedge clk);
        @(negedge clk);
        mem_w_a[2] = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (rdy_a[2]) seen++;
        end
        chk("abort no ready", 16'(seen), 16'h0000);
        access(2, 1'b1, 1'b0, 16'h0020, 16'h0000, 4'h0, rv);
        chk("abort ram kept", rv, 16'h5A5A);

        // abort by reset in the 2nd wait cycle
        access(2, 1'b0, 1'b1, 16'hF000, 16'h0077, 4'h0, rv);
        mem_w_a[2] = 1'b1; addr_a[2] = 16'h0020; wdata_a[2] = 16'hDEAD;
        @(negedge clk);
        @(negedge clk);
        rst_a[2] = 1'b1; mem_w_a[2] = 1'b0;
        @(negedge clk);
        rst_a[2] = 1'b0;
        out_m[2] = 16'h0000; last_rd[2] = 16'h0000;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (rdy_a[2]) seen++;
        end
        chk("rst abort no ready", 16'(seen), 16'h0000);
        chk("rst outvalue", outv_a[2], 16'h0000);
        chk("rst readBus", rbus_a[2], 16'h0000);
        access(2, 1'b1, 1'b0, 16'h0020, 16'h0000, 4'h0, rv);
        chk("rst ram kept", rv, 16'h5A5A);

        // cycle counter: two reads whose request edges are 10 clocks apart
        access(0, 1'b1, 1'b0, 16'hF002, 16'h0000, 4'h0, rv1);
        repeat (7) @(negedge clk);
        access(0, 1'b1, 1'b0, 16'hF002, 16'h0000, 4'h0, rv2);
`ifdef DMEM_MMIO_EN
        chk("counter delta", rv2 - rv1, 16'd10);
        // counter wrap: reads captured at 0xFFFE and two clocks later
        seen = 0;
        while ((cyc[1] != 16'hFFFE) && (seen < 70000)) begin
            @(negedge clk);
            seen++;
        end
        chk("wrap reach", {15'h0, (cyc[1] == 16'hFFFE)}, 16'h0001);
        access(1, 1'b1, 1'b0, 16'hF002, 16'h0000, 4'h0, rv1);
        access(1, 1'b1, 1'b0, 16'hF002, 16'h0000, 4'h0, rv2);
        chk("wrap value", rv2, 16'h0000);
        chk("wrap delta", rv2 - rv1, 16'd2);
`else
        chk("counter absent", rv2 - rv1, 16'd0);
`endif

        // randomized traffic against the model
        for (int d = 0; d < 3; d++) begin
            for (int a = 0; a < 16; a++) begin
                access(d, 1'b0, 1'b1, 16'(a), 16'($urandom), 4'h0, rv);
            end
            for (int n = 0; n < 30; n++) begin
                int          kind;
                logic [1:0]  op;
                logic [15:0] ra;
                logic [3:0]  iv;
                kind = $urandom_range(0, 9);
                op   = 2'($urandom_range(1, 3));
                iv   = 4'($urandom);
                case (kind)
                    0, 1, 2, 3, 4: ra = 16'($urandom_range(0, 15));
                    5, 6:          ra = 16'hF000;
                    7, 9:          ra = 16'hF001;
                    default:       ra = 16'h4000 | 16'($urandom_range(0, 255));
                endcase
                access(d, op[0], op[1], ra, 16'($urandom), iv, rv);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
